mold_msg_mask_sched: RTL and testbench

//  Per-beat byte-lane scheduler for MoldUDP64 message payloads on the 64-bit datapath.
//  - Accepts one message length per start handshake and slices it into 8-byte beats.
//  - For each beat, emits the byte count and its thermometer keep mask.
//  - Sits between the header parser (source of message length) and the payload

---
 rtl/mold_msg_mask_sched.sv | 111 +++++++++++
 tb/tb_mold_msg_mask_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mold_msg_mask_sched.sv
// rtl/mold_msg_mask_sched.sv - per-beat byte count and keep-mask scheduler for MoldUDP64 payloads
// Optional length check: define MOLD_MSG_SCHED_OVERSIZE_CHK_EN to add oversize_o.
module mold_msg_mask_sched #(
    parameter int KEEP_W  = 8,
    parameter int KEEP_LW = 4,
    parameter int ML_W    = 16
`ifdef MOLD_MSG_SCHED_OVERSIZE_CHK_EN
    ,
    parameter int MAX_MSG_LEN = 1500
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_v_i,
    input  logic [ML_W-1:0]    start_len_i,
    output logic               start_ready_o,
    input  logic               beat_ready_i,
    output logic               beat_v_o,
    output logic [KEEP_LW-1:0] beat_len_o,
    output logic [KEEP_W-1:0]  beat_mask_o,
    output logic               beat_last_o
`ifdef MOLD_MSG_SCHED_OVERSIZE_CHK_EN
    ,
    output logic               oversize_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    localparam logic [ML_W-1:0]    KEEP_W_ML = ML_W'(KEEP_W);
    localparam logic [KEEP_LW-1:0] KEEP_W_LW = KEEP_LW'(KEEP_W);

    state_e            state_q, state_d;
    logic [ML_W-1:0]   rem_q, rem_d;
    logic              ovs_q, ovs_d;
    logic              beat_fire;
    logic              start_fire;
    logic              reject;

    // Beat outputs are decoded from flops only so a stalled beat never moves.
    always_comb begin
        beat_v_o    = (state_q == DATA);
        beat_len_o  = '0;
        beat_last_o = 1'b0;
        if (state_q == DATA) begin
            beat_len_o  = (rem_q >= KEEP_W_ML) ? KEEP_W_LW : rem_q[KEEP_LW-1:0];
            beat_last_o = (rem_q <= KEEP_W_ML);
        end
    end

    always_comb begin
        beat_mask_o = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            beat_mask_o[i] = (beat_len_o > KEEP_LW'(i));
        end
    end

    assign beat_fire     = beat_v_o & beat_ready_i;
    assign start_ready_o = ~reset & ((state_q == IDLE) | (beat_fire & beat_last_o));
    assign start_fire    = start_v_i & start_ready_o;

`ifdef MOLD_MSG_SCHED_OVERSIZE_CHK_EN
    assign reject     = (32'(start_len_i) > MAX_MSG_LEN);
    assign oversize_o = ovs_q;
`else
    assign reject     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ovs_d   = 1'b0;
        if (beat_fire) begin
            rem_d = rem_q - {{(ML_W-KEEP_LW){1'b0}}, beat_len_o};
            if (beat_last_o) begin
                state_d = IDLE;
            end
        end
        // A start taken on the last-beat handshake overrides the return to IDLE.
        if (start_fire) begin
            if (reject) begin
                ovs_d   = 1'b1;
                state_d = IDLE;
            end else begin
                rem_d   = start_len_i;
                state_d = DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            ovs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ovs_q   <= ovs_d;
        end
    end

`ifndef MOLD_MSG_SCHED_OVERSIZE_CHK_EN
    logic unused_ovs;
    assign unused_ovs = ovs_q;
`endif

endmodule

// File: tb/tb_mold_msg_mask_sched.sv
// tb/tb_mold_msg_mask_sched.sv - self-checking bench for mold_msg_mask_sched
module tb_mold_msg_mask_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v_i;
    logic [15:0] start_len_i;
    logic        start_ready_o;
    logic        beat_ready_i;
    logic        beat_v_o;
    logic [3:0]  beat_len_o;
    logic [7:0]  beat_mask_o;
    logic        beat_last_o;
`ifdef MOLD_MSG_SCHED_OVERSIZE_CHK_EN
    logic        oversize_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mold_msg_mask_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start_v_i    (start_v_i),
        .start_len_i  (start_len_i),
        .start_ready_o(start_ready_o),
        .beat_ready_i (beat_ready_i),
        .beat_v_o     (beat_v_o),
        .beat_len_o   (beat_len_o),
        .beat_mask_o  (beat_mask_o),
        .beat_last_o  (beat_last_o)
`ifdef MOLD_MSG_SCHED_OVERSIZE_CHK_EN
        ,
        .oversize_o   (oversize_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: beat k of a len-byte message carries min(8, len-8k) bytes.
    function automatic int ref_nbeats(input int len);
        return (len == 0) ? 1 : (len + 7) / 8;
    endfunction

    function automatic int ref_blen(input int len, input int k);
        int left;
        left = len - 8 * k;
        return (left >= 8) ? 8 : left;
    endfunction

    function automatic logic [31:0] ref_mask(input int blen);
        return (32'd1 << blen) - 32'd1;
    endfunction

    task automatic chk_beat(input string tag, input int len, input int k);
        int bl;
        bl = ref_blen(len, k);
        chk({tag, "_v"}, 32'(beat_v_o), 32'd1);
        chk({tag, "_len"}, 32'(beat_len_o), 32'(bl));
        chk({tag, "_mask"}, 32'(beat_mask_o), ref_mask(bl));
        chk({tag, "_last"}, 32'(beat_last_o), 32'(k == ref_nbeats(len) - 1));
    endtask

    // Issues one message from IDLE and drains it with randomised backpressure.
    task automatic run_msg(input int len, input int ready_pct);
        int n;
        int k;
        int guard;
        logic r;
        start_v_i   = 1'b1;
        start_len_i = 16'(len);
        chk("start_ready_idle", 32'(start_ready_o), 32'd1);
        step();
        start_v_i = 1'b0;
        n = ref_nbeats(len);
        k = 0;
        guard = 0;
        while (k < n && guard < 4000) begin
            r = ($urandom_range(0, 99) < ready_pct);
            beat_ready_i = r;
            chk_beat("beat", len, k);
            step();
            if (r) k++;
            guard++;
        end
        if (guard >= 4000) chk("drain_timeout", 32'd1, 32'd0);
        beat_ready_i = 1'b0;
        chk("idle_after_msg", 32'(beat_v_o), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start_v_i    = 1'b1;
        start_len_i  = 16'd20;
        beat_ready_i = 1'b1;

        // Reset held with a pending start: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_start_ready", 32'(start_ready_o), 32'd0);
            chk("rst_beat_v", 32'(beat_v_o), 32'd0);
            chk("rst_beat_len", 32'(beat_len_o), 32'd0);
            chk("rst_beat_mask", 32'(beat_mask_o), 32'd0);
            chk("rst_beat_last", 32'(beat_last_o), 32'd0);
        end
        start_v_i = 1'b0;
        reset     = 1'b0;
        #1;
        chk("post_rst_ready", 32'(start_ready_o), 32'd1);
        step();
        chk("post_rst_no_load", 32'(beat_v_o), 32'd0);

        run_msg(13, 100);

        // len=16 with ready pattern 1,0,0,1: stall must hold beat 2.
        start_v_i = 1'b1;
        start_len_i = 16'd16;
        step();
        start_v_i = 1'b0;
        beat_ready_i = 1'b1;
        chk_beat("s16_b0", 16, 0);
        step();
        beat_ready_i = 1'b0;
        chk_beat("s16_b1a", 16, 1);
        step();
        chk_beat("s16_b1b", 16, 1);
        step();
        beat_ready_i = 1'b1;
        chk_beat("s16_b1c", 16, 1);
        step();
        chk("s16_no_third", 32'(beat_v_o), 32'd0);

        // Zero length, with len=3 chained on its only handshake.
        start_v_i = 1'b1;
        start_len_i = 16'd0;
        step();
        chk_beat("z0", 0, 0);
        start_len_i = 16'd3;
        chk("z0_chain_ready", 32'(start_ready_o), 32'd1);
        step();
        start_v_i = 1'b0;
        chk_beat("z3", 3, 0);
        step();
        chk("z3_done", 32'(beat_v_o), 32'd0);

        // Reset mid-message drops the remainder.
        start_v_i = 1'b1;
        start_len_i = 16'd40;
        step();
        start_v_i = 1'b0;
        chk_beat("m40_b0", 40, 0);
        step();
        chk_beat("m40_b1", 40, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("m40_dropped", 32'(beat_v_o), 32'd0);
        step();
        chk("m40_still_idle", 32'(beat_v_o), 32'd0);
        run_msg(1, 100);

        // Back-to-back random messages chained on last-beat handshakes.
        begin
            int len_a;
            int len_b;
            for (int m = 0; m < 10; m++) begin
                len_a = $urandom_range(0, 40);
                len_b = $urandom_range(0, 40);
                start_v_i = 1'b1;
                start_len_i = 16'(len_a);
                step();
                start_v_i = 1'b0;
                beat_ready_i = 1'b1;
                for (int k = 0; k < ref_nbeats(len_a); k++) begin
                    chk_beat("b2b_a", len_a, k);
                    if (k == ref_nbeats(len_a) - 1) begin
                        start_v_i = 1'b1;
                        start_len_i = 16'(len_b);
                    end
                    step();
                    start_v_i = 1'b0;
                end
                for (int k = 0; k < ref_nbeats(len_b); k++) begin
                    chk_beat("b2b_b", len_b, k);
                    step();
                end
                beat_ready_i = 1'b0;
                chk("b2b_idle", 32'(beat_v_o), 32'd0);
            end
        end

        for (int m = 0; m < 25; m++) begin
            run_msg($urandom_range(0, 120), 60);
        end

`ifdef MOLD_MSG_SCHED_OVERSIZE_CHK_EN
        start_v_i = 1'b1;
        start_len_i = 16'd1501;
        chk("ovs_ready", 32'(start_ready_o), 32'd1);
        step();
        start_v_i = 1'b0;
        chk("ovs_pulse", 32'(oversize_o), 32'd1);
        chk("ovs_no_beat", 32'(beat_v_o), 32'd0);
        step();
        chk("ovs_pulse_end", 32'(oversize_o), 32'd0);
        chk("ovs_still_idle", 32'(beat_v_o), 32'd0);
        run_msg(1500, 100);
        chk("max_no_ovs", 32'(oversize_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
